// File: rtl/sensor_pkg.sv
// Shared types and helpers for the image-sensor model.
// Holds the frame-sequencer state encoding and the pixel scaling function.
package sensor_pkg;

   localparam int ADC_BITS_DEF = 8;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ERASE   = 3'd1,
      S_EXPOSE  = 3'd2,
      S_CONVERT = 3'd3,
      S_READ    = 3'd4
   } state_e;

   // Product taken at full width so the clamp sees the true value.
   function automatic logic [31:0] sat_scale(
      input logic [31:0] s,
      input logic [31:0] e,
      input logic [31:0] maxv
   );
      logic [31:0] p;
      p = (s * e) >> 4;
      return (p > maxv) ? maxv : p;
   endfunction

endpackage

// File: rtl/sensor_if.sv
// Observation bundle of the sensor: sequencer state, ADC ramp and pixel stream.
interface sensor_if #(
   parameter int W  = 128,
   parameter int H  = 128,
   parameter int AB = 8
) ();
   logic [2:0]           state;
   logic [AB-1:0]        adc_ramp;
   logic                 pixel_valid;
   logic [AB-1:0]        pixel_data;
   logic [$clog2(H)-1:0] pixel_row;
   logic [$clog2(W)-1:0] pixel_col;
   logic                 frame_start;
   logic                 frame_done;

   modport master (
      output state, adc_ramp, pixel_valid, pixel_data,
      output pixel_row, pixel_col, frame_start, frame_done
   );

   modport slave (
      input state, adc_ramp, pixel_valid, pixel_data,
      input pixel_row, pixel_col, frame_start, frame_done
   );
endinterface

// File: rtl/sensor_pixel_array.sv
// Behavioural pixel array: scene model plus single-slope ramp comparator.
// SENSOR_TEST_PATTERN_EN replaces the scene with a checkerboard.
module sensor_pixel_array
   import sensor_pkg::*;
#(
   parameter int RW       = 7,
   parameter int CW       = 7,
   parameter int ADC_BITS = ADC_BITS_DEF
) (
   input  logic [RW-1:0]       row_i,
   input  logic [CW-1:0]       col_i,
   input  logic [7:0]          exposure_i,
   output logic [ADC_BITS-1:0] pix_o
);
   localparam logic [31:0] MAXV = (32'd1 << ADC_BITS) - 32'd1;

`ifdef SENSOR_TEST_PATTERN_EN
   assign pix_o = (row_i[0] ^ col_i[0]) ? '1 : '0;
`else
   logic [31:0] scene;
   logic [31:0] target;

   assign scene  = (32'(row_i) + 32'(col_i)) & MAXV;
   assign target = sat_scale(scene, 32'(exposure_i), MAXV);

   // Unit-step ramp covers every code, so the trip count equals the target.
   assign pix_o = ADC_BITS'(target);
`endif

endmodule

// File: rtl/sensor_top.sv
// Image-sensor top: autonomous IDLE/ERASE/EXPOSE/CONVERT/READ sequencer.
// Streams one registered pixel per clock; see SENSOR_TEST_PATTERN_EN.
module sensor_top
   import sensor_pkg::*;
#(
   parameter int PIXEL_ARRAY_WIDTH  = 128,
   parameter int PIXEL_ARRAY_HEIGHT = 128,
   parameter int ERASE_CYCLES       = 4,
   parameter int EXPOSURE_CYCLES    = 16,
   parameter int ADC_BITS           = ADC_BITS_DEF
) (
   input logic      clk,
   input logic      reset,
   sensor_if.master sens
);
   localparam int W  = PIXEL_ARRAY_WIDTH;
   localparam int H  = PIXEL_ARRAY_HEIGHT;
   localparam int RW = $clog2(H);
   localparam int CW = $clog2(W);

   state_e              state_q, state_d;
   logic [15:0]         cnt_q, cnt_d;
   logic [ADC_BITS-1:0] ramp_q, ramp_d;
   logic                valid_q, valid_d;
   logic [ADC_BITS-1:0] data_q, data_d;
   logic [RW-1:0]       row_q, row_d;
   logic [CW-1:0]       col_q, col_d;
   logic                fs_q, fs_d;
   logic                fd_q, fd_d;

   logic                last_col;
   logic [RW-1:0]       row_a;
   logic [CW-1:0]       col_a;
   logic                last_a;
   logic [ADC_BITS-1:0] pix;

   assign last_col = (col_q == CW'(W - 1));

   // Coordinates of the pixel to be presented next cycle.
   assign row_a = (state_q != S_READ) ? '0 :
                  last_col ? row_q + RW'(1) : row_q;
   assign col_a = (state_q != S_READ || last_col) ? '0 :
                  col_q + CW'(1);
   assign last_a = (row_a == RW'(H - 1)) &&
                   (col_a == CW'(W - 1));

   sensor_pixel_array #(
      .RW       (RW),
      .CW       (CW),
      .ADC_BITS (ADC_BITS)
   ) u_array (
      .row_i      (row_a),
      .col_i      (col_a),
      .exposure_i (8'(EXPOSURE_CYCLES)),
      .pix_o      (pix)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 16'd1;
      ramp_d  = '0;
      valid_d = 1'b0;
      data_d  = '0;
      row_d   = '0;
      col_d   = '0;
      fs_d    = 1'b0;
      fd_d    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            state_d = S_ERASE;
            cnt_d   = '0;
         end
         S_ERASE: begin
            if (cnt_q == 16'(ERASE_CYCLES - 1)) begin
               state_d = S_EXPOSE;
               cnt_d   = '0;
            end
         end
         S_EXPOSE: begin
            if (cnt_q == 16'(EXPOSURE_CYCLES - 1)) begin
               state_d = S_CONVERT;
               cnt_d   = '0;
            end
         end
         S_CONVERT: begin
            cnt_d = '0;
            if (ramp_q == '1) begin
               state_d = S_READ;
               valid_d = 1'b1;
               row_d   = row_a;
               col_d   = col_a;
               data_d  = pix;
               fs_d    = 1'b1;
               fd_d    = last_a;
            end else begin
               ramp_d = ramp_q + ADC_BITS'(1);
            end
         end
         S_READ: begin
            cnt_d = '0;
            if (fd_q) begin
               state_d = S_IDLE;
            end else begin
               valid_d = 1'b1;
               row_d   = row_a;
               col_d   = col_a;
               data_d  = pix;
               fd_d    = last_a;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ramp_q  <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         row_q   <= '0;
         col_q   <= '0;
         fs_q    <= 1'b0;
         fd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ramp_q  <= ramp_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         row_q   <= row_d;
         col_q   <= col_d;
         fs_q    <= fs_d;
         fd_q    <= fd_d;
      end
   end

   assign sens.state       = state_q;
   assign sens.adc_ramp    = ramp_q;
   assign sens.pixel_valid = valid_q;
   assign sens.pixel_data  = data_q;
   assign sens.pixel_row   = row_q;
   assign sens.pixel_col   = col_q;
   assign sens.frame_start = fs_q;
   assign sens.frame_done  = fd_q;

endmodule

// File: tb/tb_sensor_top.sv
// Directed bench for sensor_top: default 128x128 instance plus a 64x64
// instance with EXPOSURE_CYCLES=64 for the scaling and saturation cases.
module tb_sensor_top;

   logic clk = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   sensor_if #(.W(128), .H(128), .AB(8)) s1 ();
   sensor_if #(.W(64),  .H(64),  .AB(8)) s2 ();

   sensor_top #(
      .PIXEL_ARRAY_WIDTH  (128),
      .PIXEL_ARRAY_HEIGHT (128),
      .ERASE_CYCLES       (4),
      .EXPOSURE_CYCLES    (16),
      .ADC_BITS           (8)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .sens  (s1.master)
   );

   sensor_top #(
      .PIXEL_ARRAY_WIDTH  (64),
      .PIXEL_ARRAY_HEIGHT (64),
      .ERASE_CYCLES       (4),
      .EXPOSURE_CYCLES    (64),
      .ADC_BITS           (8)
   ) u_dut64 (
      .clk   (clk),
      .reset (reset),
      .sens  (s2.master)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input int got, input int want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   function automatic int pix_ref(input int r, input int c, input int e);
      int v;
`ifdef SENSOR_TEST_PATTERN_EN
      v = ((r ^ c) & 1) != 0 ? 255 : 0;
      if (e < 0) v = 0;
`else
      v = (((r + c) % 256) * e) >> 4;
      if (v > 255) v = 255;
`endif
      return v;
   endfunction

   task automatic chk_zero(input string tag);
      chk({tag, "_state"}, int'(s1.state), 0);
      chk({tag, "_ramp"},  int'(s1.adc_ramp), 0);
      chk({tag, "_valid"}, int'(s1.pixel_valid), 0);
      chk({tag, "_data"},  int'(s1.pixel_data), 0);
      chk({tag, "_row"},   int'(s1.pixel_row), 0);
      chk({tag, "_col"},   int'(s1.pixel_col), 0);
      chk({tag, "_fs"},    int'(s1.frame_start), 0);
      chk({tag, "_fd"},    int'(s1.frame_done), 0);
   endtask

   // Hand-computed readout points for the default instance.
   int pt_r [6] = '{0, 0, 0,   1, 1, 127};
   int pt_c [6] = '{0, 1, 127, 0, 1, 127};
`ifdef SENSOR_TEST_PATTERN_EN
   int pt_v [6] = '{0, 255, 255, 255, 0, 0};
   int want11   = 0;
   int want4030 = 0;
`else
   int pt_v [6] = '{0, 1, 127, 1, 2, 254};
   int want11   = 8;
   int want4030 = 255;
`endif

   int g11   = -1;
   int g4030 = -1;

   always @(negedge clk) begin
      if (s2.pixel_valid === 1'b1) begin
         if (s2.pixel_row == 6'd1 && s2.pixel_col == 6'd1)
            g11 = int'(s2.pixel_data);
         if (s2.pixel_row == 6'd40 && s2.pixel_col == 6'd30)
            g4030 = int'(s2.pixel_data);
      end
   end

   initial begin
      int es;
      int er;
      int nbad_pix;
      int k;
      int nfd;

      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_zero("rst");
      reset = 1'b0;

      for (int t = 0; t <= 277; t++) begin
         if (t > 0) @(negedge clk);
         es = (t == 0) ? 0 : (t <= 4) ? 1 : (t <= 20) ? 2 :
              (t <= 276) ? 3 : 4;
         er = (t >= 21 && t <= 276) ? t - 21 : 0;
         chk($sformatf("state_t%0d", t), int'(s1.state), es);
         chk($sformatf("ramp_t%0d", t), int'(s1.adc_ramp), er);
      end
      chk("first_valid", int'(s1.pixel_valid), 1);
      chk("first_fs", int'(s1.frame_start), 1);
      chk("first_row", int'(s1.pixel_row), 0);
      chk("first_col", int'(s1.pixel_col), 0);

      nbad_pix = 0;
      for (int idx = 0; idx < 16384; idx++) begin
         int r;
         int c;
         if (idx > 0) @(negedge clk);
         r = idx / 128;
         c = idx % 128;
         if (s1.pixel_valid !== 1'b1 ||
             int'(s1.pixel_row) != r ||
             int'(s1.pixel_col) != c ||
             int'(s1.pixel_data) != pix_ref(r, c, 16) ||
             s1.frame_start !== (idx == 0) ||
             s1.frame_done !== (idx == 16383))
            nbad_pix++;
         for (int p = 0; p < 6; p++)
            if (r == pt_r[p] && c == pt_c[p])
               chk($sformatf("pix_%0d_%0d", r, c),
                   int'(s1.pixel_data), pt_v[p]);
         if (idx == 16383)
            chk("fd_last", int'(s1.frame_done), 1);
      end
      chk("pix_sweep_bad", nbad_pix, 0);

      @(negedge clk);
      chk("post_state", int'(s1.state), 0);
      chk("post_valid", int'(s1.pixel_valid), 0);
      chk("post_data", int'(s1.pixel_data), 0);
      chk("post_fd", int'(s1.frame_done), 0);

      k = 0;
      while (!(s1.pixel_valid === 1'b1 && s1.pixel_row == 7'd5 &&
               s1.pixel_col == 7'd3) && k < 20000) begin
         @(negedge clk);
         k++;
      end
      chk("reach_5_3", int'(k < 20000), 1);

      reset = 1'b1;
      @(negedge clk);
      chk_zero("mid");
      reset = 1'b0;
      nfd = 0;
      for (int t = 1; t <= 300; t++) begin
         @(negedge clk);
         if (t == 1)
            chk("restart_state", int'(s1.state), 1);
         if (s1.frame_done === 1'b1) nfd++;
      end
      chk("no_fd_after_abort", nfd, 0);

      chk("e64_1_1", g11, want11);
      chk("e64_40_30", g4030, want4030);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
